// File: rtl/card_pkg.sv
// Shared constants and index helpers for the card dealer: suit codes, deck geometry,
// controller state encoding and grant IDs.
package card_pkg;

  localparam logic [1:0] SUIT_DIAMOND = 2'd0;
  localparam logic [1:0] SUIT_CLUB    = 2'd1;
  localparam logic [1:0] SUIT_HEART   = 2'd2;
  localparam logic [1:0] SUIT_SPADE   = 2'd3;

  localparam int RANKS     = 13;
  localparam int DECK_SIZE = 52;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  localparam logic GNT_PLAYER = 1'b0;
  localparam logic GNT_DEALER = 1'b1;

  // Invalid ranks may yield out-of-deck indices; callers gate on rank_valid.
  function automatic logic [5:0] card_idx(input logic [3:0] value, input logic [1:0] suit);
    return 6'(suit) * 6'(RANKS) + 6'(value) - 6'd1;
  endfunction

  function automatic logic rank_valid(input logic [3:0] value);
    return (value >= 4'd1) && (value <= 4'(RANKS));
  endfunction

  function automatic logic [1:0] idx_suit(input logic [5:0] idx);
    logic [1:0] s;
    if (idx >= 6'(3 * RANKS))      s = SUIT_SPADE;
    else if (idx >= 6'(2 * RANKS)) s = SUIT_HEART;
    else if (idx >= 6'(RANKS))     s = SUIT_CLUB;
    else                           s = SUIT_DIAMOND;
    return s;
  endfunction

  function automatic logic [3:0] idx_rank(input logic [5:0] idx);
    return 4'(idx - 6'(idx_suit(idx)) * 6'(RANKS)) + 4'd1;
  endfunction

endpackage

// File: rtl/deck_tracker.sv
// Holds the dealt-card mask and the undealt count; tests one index combinationally,
// marks one index or clears the whole deck per clock.
module deck_tracker
  import card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] test_idx_i,
  output logic       test_free_o,
  input  logic       mark_i,
  input  logic [5:0] mark_idx_i,
  input  logic       clear_all_i,
  output logic [5:0] cards_left_o
);

  logic [DECK_SIZE-1:0] mask_q, mask_d;
  logic [5:0]           left_q, left_d;
  logic                 mark_ok;

  assign test_free_o  = (test_idx_i < 6'(DECK_SIZE)) && !mask_q[test_idx_i];
  assign cards_left_o = left_q;

  // Guarding on an unmarked bit keeps the count consistent with the mask and off zero.
  assign mark_ok = (mark_idx_i < 6'(DECK_SIZE)) && !mask_q[mark_idx_i] && (left_q != 6'd0);

  always_comb begin
    mask_d = mask_q;
    left_d = left_q;
    if (clear_all_i) begin
      mask_d = '0;
      left_d = 6'(DECK_SIZE);
    end else if (mark_i && mark_ok) begin
      mask_d[mark_idx_i] = 1'b1;
      left_d             = left_q - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      left_q <= 6'(DECK_SIZE);
    end else begin
      mask_q <= mask_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/card_dealer_ctrl.sv
// Draw controller: arbitrates player/dealer requests, retries RNG samples against the
// dealt mask, and falls back to a linear scan so every granted draw completes.
module card_dealer_ctrl
  import card_pkg::*;
#(
  parameter int MAX_RETRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       player_req_i,
  input  logic       dealer_req_i,
  input  logic       shuffle_i,
  input  logic [3:0] rng_value_i,
  input  logic [1:0] rng_suit_i,
  output logic       player_ack_o,
  output logic       dealer_ack_o,
  output logic [3:0] card_value_o,
  output logic [1:0] card_suit_o,
  output logic       busy_o,
  output logic       deck_empty_o,
  output logic [5:0] cards_left_o
);

  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [5:0]    scan_idx_q, scan_idx_d;
  logic [3:0]    samp_value_q, samp_value_d;
  logic [1:0]    samp_suit_q, samp_suit_d;
  logic          shuffle_pend_q, shuffle_pend_d;
  logic          player_ack_q, player_ack_d;
  logic          dealer_ack_q, dealer_ack_d;
  logic [3:0]    card_value_q, card_value_d;
  logic [1:0]    card_suit_q, card_suit_d;

  logic [5:0] test_idx;
  logic [5:0] cards_left;
  logic       test_free, hit, mark, clear_all, deck_empty;
  logic       grant_en, grant_id;
  logic [3:0] deliver_value;
  logic [1:0] deliver_suit;

  deck_tracker u_deck (
    .clk          (clk),
    .rst          (rst),
    .test_idx_i   (test_idx),
    .test_free_o  (test_free),
    .mark_i       (mark),
    .mark_idx_i   (test_idx),
    .clear_all_i  (clear_all),
    .cards_left_o (cards_left)
  );

  assign deck_empty = (cards_left == 6'd0);

  // An invalid rank can alias onto a real index, so validity gates the hit, not just the tracker.
  always_comb begin
    test_idx      = (state_q == ST_SCAN) ? scan_idx_q : card_idx(samp_value_q, samp_suit_q);
    hit           = test_free && ((state_q == ST_SCAN) || rank_valid(samp_value_q));
    deliver_value = (state_q == ST_SCAN) ? idx_rank(scan_idx_q) : samp_value_q;
    deliver_suit  = (state_q == ST_SCAN) ? idx_suit(scan_idx_q) : samp_suit_q;
    grant_id      = (player_req_i && (!dealer_req_i || last_grant_q == GNT_DEALER))
                    ? GNT_PLAYER : GNT_DEALER;
    grant_en      = player_req_i || dealer_req_i;
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    gnt_d          = gnt_q;
    retry_d        = retry_q;
    scan_idx_d     = scan_idx_q;
    samp_value_d   = samp_value_q;
    samp_suit_d    = samp_suit_q;
    shuffle_pend_d = shuffle_pend_q;
    card_value_d   = card_value_q;
    card_suit_d    = card_suit_q;
    player_ack_d   = 1'b0;
    dealer_ack_d   = 1'b0;
    mark           = 1'b0;
    clear_all      = 1'b0;

    if (state_q != ST_IDLE && shuffle_i) shuffle_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (shuffle_i || shuffle_pend_q) begin
          clear_all      = 1'b1;
          shuffle_pend_d = 1'b0;
        end else if (!player_ack_q && !dealer_ack_q && !deck_empty && grant_en) begin
          gnt_d        = grant_id;
          last_grant_d = grant_id;
          samp_value_d = rng_value_i;
          samp_suit_d  = rng_suit_i;
          retry_d      = '0;
          state_d      = ST_DRAW;
        end
      end
      ST_DRAW, ST_SCAN: begin
        if (hit) begin
          mark         = 1'b1;
          card_value_d = deliver_value;
          card_suit_d  = deliver_suit;
          player_ack_d = (gnt_q == GNT_PLAYER);
          dealer_ack_d = (gnt_q == GNT_DEALER);
          state_d      = ST_IDLE;
        end else if (state_q == ST_SCAN) begin
          scan_idx_d = scan_idx_q + 6'd1;
        end else if (retry_q != RETRY_LAST) begin
          samp_value_d = rng_value_i;
          samp_suit_d  = rng_suit_i;
          retry_d      = retry_q + RW'(1);
        end else begin
          scan_idx_d = 6'd0;
          state_d    = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GNT_DEALER;
      gnt_q          <= GNT_PLAYER;
      retry_q        <= '0;
      scan_idx_q     <= 6'd0;
      samp_value_q   <= 4'd0;
      samp_suit_q    <= 2'd0;
      shuffle_pend_q <= 1'b0;
      player_ack_q   <= 1'b0;
      dealer_ack_q   <= 1'b0;
      card_value_q   <= 4'd0;
      card_suit_q    <= 2'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      gnt_q          <= gnt_d;
      retry_q        <= retry_d;
      scan_idx_q     <= scan_idx_d;
      samp_value_q   <= samp_value_d;
      samp_suit_q    <= samp_suit_d;
      shuffle_pend_q <= shuffle_pend_d;
      player_ack_q   <= player_ack_d;
      dealer_ack_q   <= dealer_ack_d;
      card_value_q   <= card_value_d;
      card_suit_q    <= card_suit_d;
    end
  end

  assign player_ack_o = player_ack_q;
  assign dealer_ack_o = dealer_ack_q;
  assign card_value_o = card_value_q;
  assign card_suit_o  = card_suit_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign deck_empty_o = deck_empty;
  assign cards_left_o = cards_left;

endmodule

// File: doc/card_dealer_ctrl.md
Name: card_dealer_ctrl

Overview:
- Sequences card draws from the free-running value and suit RNGs, and shares them between the player and dealer FSMs.
- Tracks which of the 52 cards are already dealt, and rejects and redraws duplicates.
- Falls back to a deterministic scan after repeated collisions, so a draw always completes while cards remain.
- Sits between the RNG blocks and the blackjack game FSMs.

Parameters:
- MAX_RETRY, 8: RNG samples attempted per draw before falling back to the linear scan (minimum 1).
- DECK_SIZE, 52: number of cards; fixed at 4 suits x 13 ranks.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- player_req  input  1  player draw request; level, held until player_ack
- dealer_req  input  1  dealer draw request; level, held until dealer_ack
- shuffle  input  1  pulse; return all cards to the deck
- rng_value  input  4  free-running rank source; valid range 1..13
- rng_suit  input  2  free-running suit source; 0 diamond, 1 club, 2 heart, 3 spade
- player_ack  output  1  one-cycle pulse; card_* valid for the player
- dealer_ack  output  1  one-cycle pulse; card_* valid for the dealer
- card_value  output  4  dealt rank 1..13
- card_suit  output  2  dealt suit
- busy  output  1  high in DRAW or SCAN
- deck_empty  output  1  high when cards_left == 0
- cards_left  output  6  undealt card count, 0..52

Behaviour:
- Reset (async, rst=1):
  - state IDLE; dealt mask all 0 (full deck); cards_left=52; deck_empty=0; busy=0.
  - Both acks 0; card_value=0; card_suit=0; retry=0; scan_idx=0; shuffle_pend=0; last_grant=dealer, so the player wins the first tie.
  - Reset mid-draw abandons the draw with no ack.
- Card index: idx = suit*13 + (value-1), 6 bits. A sample is invalid if value is 0 or 14..15; an invalid sample counts as a collision.
- IDLE, checked in priority order at each edge:
  - shuffle or shuffle_pend: clear mask, cards_left=52, shuffle_pend=0; no grant on that edge.
  - Either ack high this cycle: no grant. The requester must drop req in its ack cycle.
  - deck_empty: requests are held ungranted until a shuffle.
  - One req high: grant it.
  - Both high: grant the requester that is not last_grant.
- On grant: capture rng_value and rng_suit, retry=0, go to DRAW, update last_grant.
- DRAW, one check per cycle on the captured sample:
  - Valid and free: set mask bit, cards_left-1, load card_value/card_suit, assert the granted ack next cycle, go to IDLE.
  - Collision with retry < MAX_RETRY-1: recapture the RNGs, retry+1, stay in DRAW.
  - Collision with retry = MAX_RETRY-1: scan_idx=0, go to SCAN.
- SCAN: test one index per cycle.
  - Free: deliver as in DRAW, with value = scan_idx mod 13 + 1 and suit = scan_idx / 13.
  - Dealt: scan_idx+1.
  - Termination is guaranteed because grant requires cards_left > 0.
- Latency:
  - Minimum: req sampled at edge E0, delivery at E1, ack high during the cycle after E1.
  - Worst case: MAX_RETRY+52+1 cycles.
- card_value/card_suit hold their value from delivery until the next delivery.
- shuffle outside IDLE sets shuffle_pend and is applied on the IDLE cycle after the current delivery, before any new grant. The in-flight card is still marked, then cleared by the shuffle.
- A requester dropping req mid-draw does not cancel the draw; the ack still pulses.
- cards_left never wraps; it saturates at 0 and 52 by construction.

Decomposition:
- Shared package card_pkg holds:
  - suit codes SUIT_DIAMOND=0, SUIT_CLUB=1, SUIT_HEART=2, SUIT_SPADE=3;
  - RANKS=13, DECK_SIZE=52;
  - FSM state encoding IDLE, DRAW, SCAN;
  - grant ID encoding GNT_PLAYER=0, GNT_DEALER=1.
- One sub-module, deck_tracker, owns the 52-bit mask and count, with:
  - combinational test(idx);
  - a registered mark(idx) port;
  - a registered clear_all port;
  - the cards_left output.
- The controller FSM and arbiter stay in card_dealer_ctrl.

Test Plan:
1. After reset, player_req=1 with rng_value=5, rng_suit=2 -> player_ack pulses 2 cycles later; card_value=5, card_suit=2, cards_left=51.
2. player_req and dealer_req rise together, then again together -> player served first, dealer second; round-robin alternates on further ties.
3. Pre-deal 10 hearts then request with rng fixed at value=10, suit=2 -> 8 retries, then SCAN returns value=1, suit=0 (idx 0); ack at cycle MAX_RETRY+2.
4. Force rng_value=0 constantly -> falls back to SCAN and returns the lowest free index; no invalid card is ever output.
5. Deal all 52 cards, then request -> no ack, deck_empty=1; shuffle pulse -> cards_left=52, held request granted the cycle after.
6. Assert rst in DRAW mid-retry -> no ack, cards_left=52, and all outputs return to reset values immediately; shuffle asserted during SCAN is applied after that delivery, giving cards_left=52.
